// File: rtl/spi_ram_master.sv
`default_nettype none
// =============================================================================
// Module   : spi_ram_master
// Brief    : SPI/QSPI master for the SPI RAM slave (03h/02h/6Bh/32h), 1-4 bytes
//            per request. Define SPI_RAM_MASTER_STATS_EN for txn/read counters.
// Revision : 1.0
// =============================================================================
module spi_ram_master #(
  parameter int FAST_READ_DELAY = 2,
  parameter int DESELECT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_quad,
  input  logic [23:0] req_addr,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_select,
  output logic [3:0]  spi_d_out,
  output logic [3:0]  spi_d_oe,
  input  logic [3:0]  spi_d_in
`ifdef SPI_RAM_MASTER_STATS_EN
  ,
  output logic [15:0] txn_count,
  output logic [15:0] rd_count
`endif
);

  localparam int c_CNT_MAX = (FAST_READ_DELAY > DESELECT_CYCLES)
                           ? ((FAST_READ_DELAY > 32) ? FAST_READ_DELAY : 32)
                           : ((DESELECT_CYCLES > 32) ? DESELECT_CYCLES : 32);
  localparam int c_CNT_W = $clog2(c_CNT_MAX);

  localparam logic [7:0] c_OP_READ   = 8'h03;
  localparam logic [7:0] c_OP_WRITE  = 8'h02;
  localparam logic [7:0] c_OP_QREAD  = 8'h6B;
  localparam logic [7:0] c_OP_QWRITE = 8'h32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_CMD   = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_END   = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_busy;
  logic               r_rsp_valid;
  logic [31:0]        r_rdata;
  logic               r_sclk;
  logic               r_sel;
  logic [3:0]         r_dout;
  logic [3:0]         r_doe;
  logic               r_phase;
  logic               r_write;
  logic               r_quad;
  logic [1:0]         r_len;
  logic [31:0]        r_cmd;
  logic [31:0]        r_tx;
  logic [31:0]        r_rx;
  logic [c_CNT_W-1:0] r_cnt;

  logic [7:0]         w_opcode;
  logic [c_CNT_W-1:0] w_data_last;
  logic [31:0]        w_rx_swap;
  logic [31:0]        w_rdata;

  always_comb begin
    w_opcode = c_OP_READ;
    if (req_write) w_opcode = req_quad ? c_OP_QWRITE : c_OP_WRITE;
    else           w_opcode = req_quad ? c_OP_QREAD  : c_OP_READ;
  end

  assign w_data_last = r_quad ? c_CNT_W'({r_len, 1'b1}) : c_CNT_W'({r_len, 3'b111});

  // Byte 0 arrives first, so it sits highest among the received bits; swap
  // bytes and shift down so byte i lands at [8i+7:8i] and unused bytes are 0.
  assign w_rx_swap = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
  assign w_rdata   = w_rx_swap >> {~r_len, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_sclk      <= 1'b0;
      r_sel       <= 1'b1;
      r_dout      <= 4'b0000;
      r_doe       <= 4'b0001;
      r_phase     <= 1'b0;
      r_write     <= 1'b0;
      r_quad      <= 1'b0;
      r_len       <= 2'd0;
      r_cmd       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (req_valid && r_ready) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_sel   <= 1'b0;
            r_write <= req_write;
            r_quad  <= req_quad;
            r_len   <= req_len;
            r_cmd   <= {w_opcode, req_addr};
            r_tx    <= {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
            r_rx    <= '0;
            r_state <= ST_SEL;
          end
        end

        ST_SEL: begin
          r_dout  <= {3'b000, r_cmd[31]};
          r_doe   <= 4'b0001;
          r_phase <= 1'b0;
          r_cnt   <= c_CNT_W'(31);
          r_state <= ST_CMD;
        end

        ST_CMD: begin
          r_phase <= ~r_phase;
          r_sclk  <= ~r_phase;
          if (r_phase) begin
            if (r_cnt != '0) begin
              r_cnt  <= r_cnt - c_CNT_W'(1);
              r_cmd  <= {r_cmd[30:0], 1'b0};
              r_dout <= {3'b000, r_cmd[30]};
            end else if (r_quad && !r_write) begin
              r_doe   <= 4'b0000;
              r_dout  <= 4'b0000;
              r_cnt   <= c_CNT_W'(FAST_READ_DELAY - 1);
              r_state <= ST_DUMMY;
            end else begin
              r_cnt   <= w_data_last;
              r_state <= ST_DATA;
              if (r_quad) begin
                r_doe  <= 4'b1111;
                r_dout <= r_tx[31:28];
              end else begin
                r_dout <= r_write ? {3'b000, r_tx[31]} : 4'b0000;
              end
            end
          end
        end

        ST_DUMMY: begin
          r_phase <= ~r_phase;
          r_sclk  <= ~r_phase;
          if (r_phase) begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_CNT_W'(1);
            end else begin
              r_cnt   <= w_data_last;
              r_state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          r_phase <= ~r_phase;
          r_sclk  <= ~r_phase;
          if (!r_phase) begin
            // End of the LOW phase: the slave has had half a bit to settle.
            if (r_quad) r_rx <= {r_rx[27:0], spi_d_in};
            else        r_rx <= {r_rx[30:0], spi_d_in[1]};
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
            if (r_quad) begin
              r_tx   <= {r_tx[27:0], 4'b0000};
              r_dout <= r_write ? r_tx[27:24] : 4'b0000;
            end else begin
              r_tx   <= {r_tx[30:0], 1'b0};
              r_dout <= r_write ? {3'b000, r_tx[30]} : 4'b0000;
            end
          end else begin
            r_sel       <= 1'b1;
            r_doe       <= 4'b0001;
            r_dout      <= 4'b0000;
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_write ? 32'h0 : w_rdata;
            r_cnt       <= c_CNT_W'(DESELECT_CYCLES - 1);
            r_state     <= ST_END;
          end
        end

        ST_END: begin
          r_sclk  <= 1'b0;
          r_phase <= 1'b0;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end else begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign spi_clk    = r_sclk;
  assign spi_select = r_sel;
  assign spi_d_out  = r_dout;
  assign spi_d_oe   = r_doe;

`ifdef SPI_RAM_MASTER_STATS_EN
  logic [15:0] r_txn_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= 16'd0;
      r_rd_count  <= 16'd0;
    end else if (r_rsp_valid) begin
      r_txn_count <= r_txn_count + 16'd1;
      if (!r_write) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign txn_count = r_txn_count;
  assign rd_count  = r_rd_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_master.sv
`default_nettype none
// =============================================================================
// Module   : tb_spi_ram_master
// Brief    : Vector table + scoreboard bench with a behavioural SPI RAM slave.
// Revision : 1.0
// =============================================================================
module tb_spi_ram_master;

  localparam int FRD = 2;
  localparam int DES = 2;
  localparam int NV  = 13;

  typedef struct {
    logic        wr;
    logic        qd;
    logic [23:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_quad;
  logic [23:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        spi_clk;
  logic        spi_select;
  logic [3:0]  spi_d_out;
  logic [3:0]  spi_d_oe;
  logic [3:0]  spi_d_in;

  spi_ram_master #(
    .FAST_READ_DELAY (FRD),
    .DESELECT_CYCLES (DES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_quad   (req_quad),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .spi_clk    (spi_clk),
    .spi_select (spi_select),
    .spi_d_out  (spi_d_out),
    .spi_d_oe   (spi_d_oe),
    .spi_d_in   (spi_d_in)
  );

  initial forever #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          n_rsp;
  int          cyc;
  int          sel_run;
  int          acc_gap;
  int          oe_err;
  logic [31:0] last_cmd;
  logic [7:0]  mem [256];
  vec_t        vt [NV];
  vec_t        cur;
  sb_t         sb [$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] opc(input vec_t v);
    if (v.wr) return v.qd ? 8'h32 : 8'h02;
    return v.qd ? 8'h6B : 8'h03;
  endfunction

  task cycle_count();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        sel_run = 0;
      end else begin
        if (spi_select) sel_run++;
        else            sel_run = 0;
        if (req_valid && req_ready) begin
          e.v   = cur;
          e.acc = cyc + 1;
          sb.push_back(e);
          acc_gap = sel_run;
        end
        if (rsp_valid) begin
          chk("rsp_expected", {31'd0, sb.size() != 0}, 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.v.rdata);
            chk("rsp_latency", cyc - e.acc, e.v.lat);
            chk("busy_at_rsp", {31'd0, busy}, 32'd1);
            n_rsp++;
          end
        end
      end
    end
  endtask

  // Slave: captures on spi_clk rise, updates its output after spi_clk falls.
  task slave();
    int         k;
    int         j;
    int         a;
    int         dstart;
    logic [31:0] sr;
    logic        prev;
    logic [7:0]  b;
    logic [3:0]  eoe;
    k = 0; sr = '0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || spi_select) begin
        k = 0;
        prev = 1'b0;
      end else begin
        dstart = (sr[31:24] == 8'h6B) ? 32 + FRD : 32;
        if (spi_clk && !prev) begin
          eoe = 4'b0001;
          if (k < 32) begin
            sr = {sr[30:0], spi_d_out[0]};
          end else begin
            j = k - dstart;
            if (sr[31:24] == 8'h32) eoe = 4'b1111;
            if (sr[31:24] == 8'h6B) eoe = 4'b0000;
            if (sr[31:24] == 8'h02) begin
              a = (int'(sr[7:0]) + j / 8) % 256;
              b = mem[a];
              b[7 - (j % 8)] = spi_d_out[0];
              mem[a] = b;
            end else if (sr[31:24] == 8'h32) begin
              a = (int'(sr[7:0]) + j / 2) % 256;
              b = mem[a];
              if (j % 2 == 0) b[7:4] = spi_d_out;
              else            b[3:0] = spi_d_out;
              mem[a] = b;
            end
          end
          if (spi_d_oe !== eoe) oe_err++;
          k++;
          if (k == 32) last_cmd = sr;
        end else if (!spi_clk && prev && k >= dstart) begin
          j = k - dstart;
          if (sr[31:24] == 8'h03) begin
            b = mem[(int'(sr[7:0]) + j / 8) % 256];
            spi_d_in = {2'b00, b[7 - (j % 8)], 1'b0};
          end else if (sr[31:24] == 8'h6B) begin
            b = mem[(int'(sr[7:0]) + j / 2) % 256];
            spi_d_in = (j % 2 == 0) ? b[7:4] : b[3:0];
          end
        end
        prev = spi_clk;
      end
    end
  endtask

  task start_req(input vec_t v);
    @(posedge clk); #1;
    cur       = v;
    req_write = v.wr;
    req_quad  = v.qd;
    req_addr  = v.addr;
    req_len   = v.len;
    req_wdata = v.wdata;
    req_valid = 1'b1;
  endtask

  task wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", {31'd0, req_ready}, 32'd1);
  endtask

  task drop_req();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_quad  = 1'($urandom);
    req_addr  = 24'($urandom);
    req_len   = 2'($urandom);
    req_wdata = $urandom;
  endtask

  task wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", {31'd0, n < 2000}, 32'd1);
  endtask

  task run_vec(input vec_t v);
    oe_err = 0;
    start_req(v);
    wait_accept();
    drop_req();
    wait_done();
    chk("cmd_addr", last_cmd, {opc(v), v.addr});
    chk("lane_oe", oe_err, 0);
  endtask

  vec_t va;
  vec_t vb;
  int   base;
  int   n;

  initial begin
    n_vec = 0; n_err = 0; n_rsp = 0; cyc = 0; sel_run = 0; acc_gap = 0; oe_err = 0;
    last_cmd = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_quad = 1'b0;
    req_addr = '0; req_len = '0; req_wdata = '0; spi_d_in = 4'h0;
    foreach (mem[i]) mem[i] = 8'h00;

    //        wr    qd    addr          len   wdata          rdata          lat
    vt[0]  = '{1'b1, 1'b0, 24'h000003, 2'd0, 32'h000000A5, 32'h00000000, 81};
    vt[1]  = '{1'b0, 1'b0, 24'h000003, 2'd0, 32'h0,        32'h000000A5, 81};
    vt[2]  = '{1'b1, 1'b1, 24'h000000, 2'd3, 32'h44332211, 32'h00000000, 81};
    vt[3]  = '{1'b0, 1'b1, 24'h000000, 2'd3, 32'h0,        32'h44332211, 85};
    vt[4]  = '{1'b1, 1'b0, 24'h000010, 2'd1, 32'h0000BEEF, 32'h00000000, 97};
    vt[5]  = '{1'b0, 1'b0, 24'h000010, 2'd3, 32'h0,        32'h0000BEEF, 129};
    vt[6]  = '{1'b1, 1'b1, 24'h000020, 2'd1, 32'h00001234, 32'h00000000, 73};
    vt[7]  = '{1'b0, 1'b1, 24'h00001F, 2'd2, 32'h0,        32'h00123400, 81};
    vt[8]  = '{1'b0, 1'b0, 24'h000000, 2'd1, 32'h0,        32'h00002211, 97};
    vt[9]  = '{1'b0, 1'b1, 24'h000002, 2'd0, 32'h0,        32'h00000033, 73};
    vt[10] = '{1'b1, 1'b0, 24'h0000FF, 2'd0, 32'hDEADBE77, 32'h00000000, 81};
    vt[11] = '{1'b0, 1'b1, 24'h0000FE, 2'd1, 32'h0,        32'h00007700, 77};
    vt[12] = '{1'b0, 1'b0, 24'hABCDFF, 2'd0, 32'h0,        32'h00000077, 81};

    fork
      cycle_count();
      monitor();
      slave();
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_select", {31'd0, spi_select}, 32'd1);
    chk("rst_sclk", {31'd0, spi_clk}, 32'd0);
    chk("rst_dout", {28'd0, spi_d_out}, 32'd0);
    chk("rst_oe", {28'd0, spi_d_oe}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_select", {31'd0, spi_select}, 32'd1);
    chk("idle_oe", {28'd0, spi_d_oe}, 32'd1);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_vec(vt[i]);
      if (i == 0) chk("ram_byte3", {24'd0, mem[3]}, 32'h000000A5);
      if (i == 10) chk("ram_byte_ff", {24'd0, mem[255]}, 32'h00000077);
    end

    // req_valid held high: the second request must wait out the deselect time.
    va = '{1'b1, 1'b0, 24'h000040, 2'd0, 32'h0000005A, 32'h00000000, 81};
    vb = '{1'b0, 1'b0, 24'h000040, 2'd0, 32'h0,        32'h0000005A, 81};
    base = n_rsp;
    start_req(va);
    wait_accept();
    @(posedge clk); #1;
    cur = vb; req_write = vb.wr; req_addr = vb.addr; req_len = vb.len;
    chk("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    wait_accept();
    chk("first_rsp_before_second_accept", n_rsp - base, 1);
    chk("deselect_gap_ok", {31'd0, acc_gap >= DES}, 32'd1);
    drop_req();
    wait_done();
    chk("held_two_rsp", n_rsp - base, 2);

    // Reset during the data phase of a long read.
    start_req(vt[5]);
    wait_accept();
    drop_req();
    repeat (90) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_select", {31'd0, spi_select}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd0);
    base = n_rsp;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("no_rsp_after_reset", n_rsp - base, 0);
    chk("sb_empty_after_reset", sb.size(), 0);
    run_vec(vt[3]);
    chk("rsp_after_reset", n_rsp - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
